path_request_scheduler: RTL and testbench

- Shares the single RISC-V path-planning CPU between two requesters: req0 = mission sequencer, req1 = obstacle/fault recovery.
- Round-robin arbitrates requests and latches the winner's SP/EP. Starts the CPU driver, snoops CPU stores to capture the planned node list into an internal buffer, then streams the nodes to the motion controller over a valid/ready handshake.
- Sits between the mission logic and the CPU driver / CPU core.

---
 rtl/path_request_scheduler_pkg.sv | 30 +++
 rtl/path_request_scheduler_node_fifo.sv | 63 ++++++
 rtl/path_request_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_path_request_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_request_scheduler_pkg.sv
// Shared definitions for the path request scheduler.
//   - sched_state_t   : scheduler FSM states
//   - ADDR_NODE_POINT : CPU store address that carries one planned node ID
//   - ADDR_CPU_DONE   : CPU store address that signals the end of planning
//   - NODE_W          : width of a node ID
//   - rr_pick         : round-robin winner selection for the two requesters
package path_request_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } sched_state_t;

  localparam logic [31:0] ADDR_NODE_POINT = 32'h0200_0008;
  localparam logic [31:0] ADDR_CPU_DONE   = 32'h0200_000C;
  localparam int          NODE_W          = 5;

  // One-hot winner. With both requesters active the one that did not win
  // last time (rr holds the last winner) is chosen; a sole requester always
  // wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic rr);
    if (req == 2'b11) begin
      return rr ? 2'b01 : 2'b10;
    end
    return req;
  endfunction

endpackage

// File: rtl/path_request_scheduler_node_fifo.sv
// path_node_fifo: synchronous FIFO holding the planned node list.
//   clk_3125KHz, rst_n : clock, asynchronous active-low reset (pointers/count)
//   push, push_data    : write one entry (ignored when full)
//   pop                : discard the head entry (ignored when empty)
//   flush              : empty the FIFO; wins over push and pop
//   head               : entry at the read pointer (combinational read)
//   count, full, empty : occupancy
module path_node_fifo
  #(parameter int DEPTH  = 16,
    parameter int NODE_W = 5)
  (input  logic                      clk_3125KHz,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic [NODE_W-1:0]         push_data,
   input  logic                      pop,
   input  logic                      flush,
   output logic [NODE_W-1:0]         head,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      full,
   output logic                      empty);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointers are exactly AW bits so they wrap at DEPTH without extra logic.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk_3125KHz) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/path_request_scheduler.sv
// path_request_scheduler: shares the path-planning CPU between the mission
// sequencer (requester 0) and fault recovery (requester 1).
//   req, sp0/ep0, sp1/ep1 : level requests and their start/end nodes
//   gnt                   : one-cycle one-hot grant pulse
//   busy                  : high whenever the FSM is not idle
//   cpu_sp, cpu_ep        : latched start/end nodes for the CPU driver
//   cpu_start             : start level, held START_HOLD cycles
//   CPU_MemWrite/DataAdr/WriteData : snooped CPU store bus
//   node_valid/data/last/src, node_ready : node stream to motion control
//   path_empty            : pulse, CPU finished with no nodes
//   overflow              : sticky until next grant, nodes beyond DEPTH dropped
//   timeout_err           : pulse, CPU did not finish in TIMEOUT_CYCLES
module path_request_scheduler
  import path_request_scheduler_pkg::*;
  #(parameter int DEPTH          = 16,
    parameter int START_HOLD     = 10,
    parameter int TIMEOUT_CYCLES = 3125000)
  (input  logic              clk_3125KHz,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [4:0]        sp0,
   input  logic [4:0]        ep0,
   input  logic [4:0]        sp1,
   input  logic [4:0]        ep1,
   output logic [1:0]        gnt,
   output logic              busy,
   output logic [4:0]        cpu_sp,
   output logic [4:0]        cpu_ep,
   output logic              cpu_start,
   input  logic              CPU_MemWrite,
   input  logic [31:0]       CPU_DataAdr,
   input  logic [31:0]       CPU_WriteData,
   output logic              node_valid,
   output logic [NODE_W-1:0] node_data,
   output logic              node_last,
   output logic              node_src,
   input  logic              node_ready,
   output logic              path_empty,
   output logic              overflow,
   output logic              timeout_err);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(START_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t      state, state_n;
  logic              rr, rr_n;
  logic [HW-1:0]     hold_cnt, hold_n;
  logic [TW-1:0]     tmo_cnt, tmo_n;
  logic [1:0]        gnt_n;
  logic [1:0]        win;
  logic              cpu_start_n;
  logic [4:0]        sp_n, ep_n;
  logic              src_n;
  logic              empty_n, ovf_n, tmo_err_n;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;

  logic              node_store, done_store, tmo_hit;

  assign node_store = CPU_MemWrite && (CPU_DataAdr == ADDR_NODE_POINT);
  assign done_store = CPU_MemWrite && (CPU_DataAdr == ADDR_CPU_DONE)
                      && (CPU_WriteData == 32'd1);
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign busy       = (state != ST_IDLE);
  assign node_valid = (state == ST_DRAIN) && !fifo_empty;
  assign node_last  = node_valid && (fifo_count == CW'(1));

  path_node_fifo #(.DEPTH(DEPTH), .NODE_W(NODE_W)) u_fifo (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .push        (fifo_push),
    .push_data   (CPU_WriteData[NODE_W-1:0]),
    .pop         (fifo_pop),
    .flush       (fifo_flush),
    .head        (node_data),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr          <= 1'b0;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
      gnt         <= 2'b00;
      cpu_start   <= 1'b0;
      cpu_sp      <= '0;
      cpu_ep      <= '0;
      node_src    <= 1'b0;
      path_empty  <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      rr          <= rr_n;
      hold_cnt    <= hold_n;
      tmo_cnt     <= tmo_n;
      gnt         <= gnt_n;
      cpu_start   <= cpu_start_n;
      cpu_sp      <= sp_n;
      cpu_ep      <= ep_n;
      node_src    <= src_n;
      path_empty  <= empty_n;
      overflow    <= ovf_n;
      timeout_err <= tmo_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    rr_n        = rr;
    hold_n      = hold_cnt;
    tmo_n       = tmo_cnt;
    gnt_n       = 2'b00;
    win         = 2'b00;
    cpu_start_n = 1'b0;
    sp_n        = cpu_sp;
    ep_n        = cpu_ep;
    src_n       = node_src;
    empty_n     = 1'b0;
    ovf_n       = overflow;
    tmo_err_n   = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          win        = rr_pick(req, rr);
          gnt_n      = win;
          rr_n       = win[1];
          src_n      = win[1];
          sp_n       = win[1] ? sp1 : sp0;
          ep_n       = win[1] ? ep1 : ep0;
          ovf_n      = 1'b0;
          fifo_flush = 1'b1;
          hold_n     = '0;
          tmo_n      = '0;
          state_n    = ST_LAUNCH;
        end
      end

      // The first LAUNCH cycle coincides with gnt; cpu_start rises on the
      // following edge and stays up for START_HOLD cycles. Stores seen here
      // are the driver's own init writes and are not captured.
      ST_LAUNCH: begin
        tmo_n = tmo_cnt + TW'(1);
        if (tmo_hit) begin
          tmo_err_n  = 1'b1;
          fifo_flush = 1'b1;
          state_n    = ST_IDLE;
        end else if (hold_cnt == HW'(START_HOLD)) begin
          state_n = ST_RUN;
        end else begin
          cpu_start_n = 1'b1;
          hold_n      = hold_cnt + HW'(1);
        end
      end

      // DONE takes precedence over a timeout landing in the same cycle.
      ST_RUN: begin
        tmo_n = tmo_cnt + TW'(1);
        if (done_store) begin
          if (fifo_empty) begin
            empty_n = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DRAIN;
          end
        end else if (tmo_hit) begin
          tmo_err_n  = 1'b1;
          fifo_flush = 1'b1;
          state_n    = ST_IDLE;
        end else if (node_store) begin
          if (fifo_full) ovf_n = 1'b1;
          else           fifo_push = 1'b1;
        end
      end

      ST_DRAIN: begin
        fifo_pop = node_valid && node_ready;
        if (fifo_pop && node_last) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_path_request_scheduler.sv
// Directed bench for path_request_scheduler. Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_path_request_scheduler;
  localparam int DEPTH   = 16;
  localparam int HOLD    = 10;
  localparam int TIMEOUT = 60;
  localparam logic [31:0] A_NODE = 32'h0200_0008;
  localparam logic [31:0] A_DONE = 32'h0200_000C;

  logic        clk_3125KHz = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [4:0]  sp0 = '0, ep0 = '0, sp1 = '0, ep1 = '0;
  logic [1:0]  gnt;
  logic        busy;
  logic [4:0]  cpu_sp, cpu_ep;
  logic        cpu_start;
  logic        CPU_MemWrite = 1'b0;
  logic [31:0] CPU_DataAdr = '0;
  logic [31:0] CPU_WriteData = '0;
  logic        node_valid;
  logic [4:0]  node_data;
  logic        node_last;
  logic        node_src;
  logic        node_ready = 1'b0;
  logic        path_empty, overflow, timeout_err;

  int n_checks = 0;
  int n_errs   = 0;
  int got_q[$];
  int last_q[$];
  int n_stall_checks;

  always #160 clk_3125KHz = ~clk_3125KHz;

  path_request_scheduler #(.DEPTH(DEPTH), .START_HOLD(HOLD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_3125KHz   (clk_3125KHz),
    .rst_n         (rst_n),
    .req           (req),
    .sp0           (sp0),
    .ep0           (ep0),
    .sp1           (sp1),
    .ep1           (ep1),
    .gnt           (gnt),
    .busy          (busy),
    .cpu_sp        (cpu_sp),
    .cpu_ep        (cpu_ep),
    .cpu_start     (cpu_start),
    .CPU_MemWrite  (CPU_MemWrite),
    .CPU_DataAdr   (CPU_DataAdr),
    .CPU_WriteData (CPU_WriteData),
    .node_valid    (node_valid),
    .node_data     (node_data),
    .node_last     (node_last),
    .node_src      (node_src),
    .node_ready    (node_ready),
    .path_empty    (path_empty),
    .overflow      (overflow),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a grant; returns the observed gnt, 0 if none came.
  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_3125KHz);
      if (gnt != 2'b00) begin
        g = gnt;
        break;
      end
    end
  endtask

  // Called at the grant cycle; returns once the FSM is in RUN.
  task automatic launch_wait(output int hi_cycles);
    hi_cycles = 0;
    for (int i = 0; i < HOLD + 2; i++) begin
      @(negedge clk_3125KHz);
      if (cpu_start) hi_cycles++;
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    CPU_MemWrite  = 1'b1;
    CPU_DataAdr   = addr;
    CPU_WriteData = data;
    @(negedge clk_3125KHz);
    CPU_MemWrite  = 1'b0;
    CPU_DataAdr   = '0;
    CPU_WriteData = '0;
  endtask

  // Collects beats with node_ready following rdy_pat[c%4]; checks that the
  // presented node does not change while stalled.
  task automatic drain_collect(input logic [3:0] rdy_pat);
    logic       stalled;
    logic [4:0] prev;
    stalled = 1'b0;
    prev    = '0;
    got_q.delete();
    last_q.delete();
    for (int c = 0; c < 80; c++) begin
      node_ready = rdy_pat[c % 4];
      if (node_valid) begin
        if (stalled) begin
          check("stall_stable", 32'(node_data), 32'(prev));
          n_stall_checks++;
        end
        if (node_ready) begin
          got_q.push_back(int'(node_data));
          last_q.push_back(int'(node_last));
        end
        stalled = !node_ready;
        prev    = node_data;
      end else if (got_q.size() > 0) begin
        break;
      end
      @(negedge clk_3125KHz);
    end
    node_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] g;
    int hi;
    int k;
    int exp_nodes[4];
    n_stall_checks = 0;

    // Reset values
    req = 2'b11;
    repeat (2) @(negedge clk_3125KHz);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(cpu_start), 0);
    check("rst_valid", 32'(node_valid), 0);
    check("rst_sp", 32'(cpu_sp), 0);
    check("rst_flags", 32'({path_empty, overflow, timeout_err}), 0);
    req = 2'b00;
    rst_n = 1'b1;
    @(negedge clk_3125KHz);
    check("idle_busy", 32'(busy), 0);

    // Single request from requester 0
    sp0 = 5'd3; ep0 = 5'd17; req = 2'b01;
    wait_gnt(g);
    req = 2'b00;
    check("single_gnt", 32'(g), 32'd1);
    check("single_sp", 32'(cpu_sp), 3);
    check("single_ep", 32'(cpu_ep), 17);
    check("single_src", 32'(node_src), 0);
    check("single_busy", 32'(busy), 1);
    check("start_at_gnt", 32'(cpu_start), 0);
    launch_wait(hi);
    check("start_hold", 32'(hi), HOLD);
    check("gnt_pulse", 32'(gnt), 0);
    store(A_NODE, 32'd3);
    store(A_NODE, 32'd8);
    store(A_NODE, 32'd12);
    store(A_NODE, 32'd17);
    store(A_DONE, 32'd1);
    check("done_to_valid", 32'(node_valid), 1);
    drain_collect(4'b1111);
    exp_nodes = '{3, 8, 12, 17};
    check("single_beats", 32'(got_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        check("single_node", 32'(got_q[i]), 32'(exp_nodes[i]));
        check("single_last", 32'(last_q[i]), (i == 3) ? 32'd1 : 32'd0);
      end
    end
    check("single_idle", 32'(busy), 0);

    // Contention: both held, requester 1 first (rr = 0)
    sp0 = 5'd1; ep0 = 5'd2; sp1 = 5'd5; ep1 = 5'd6; req = 2'b11;
    wait_gnt(g);
    req = 2'b01;
    check("cont_gnt1", 32'(g), 32'd2);
    check("cont_src1", 32'(node_src), 1);
    check("cont_sp1", 32'(cpu_sp), 5);
    launch_wait(hi);
    store(A_NODE, 32'd5);
    store(A_NODE, 32'd6);
    store(A_DONE, 32'd1);
    check("no_gnt_drain", 32'(gnt), 0);
    drain_collect(4'b1111);
    check("cont_beats1", 32'(got_q.size()), 2);
    if (got_q.size() == 2) check("cont_node1", 32'(got_q[1]), 6);

    // Requester 0 served next; drain under backpressure 1,0,0,1
    wait_gnt(g);
    req = 2'b00;
    check("cont_gnt0", 32'(g), 32'd1);
    check("cont_ep0", 32'(cpu_ep), 2);
    launch_wait(hi);
    store(A_NODE, 32'd1);
    store(A_NODE, 32'd9);
    store(A_NODE, 32'd2);
    store(A_DONE, 32'd1);
    drain_collect(4'b1001);
    check("bp_beats", 32'(got_q.size()), 3);
    exp_nodes = '{1, 9, 2, 0};
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) check("bp_node", 32'(got_q[i]), 32'(exp_nodes[i]));
    end
    check("bp_stall_seen", 32'(n_stall_checks > 0), 1);

    // Alternation again: rr now 0 -> requester 1; zero-node path
    req = 2'b11;
    wait_gnt(g);
    req = 2'b00;
    check("cont_gnt1b", 32'(g), 32'd2);
    launch_wait(hi);
    store(A_DONE, 32'd1);
    check("empty_pulse", 32'(path_empty), 1);
    check("empty_novalid", 32'(node_valid), 0);
    check("empty_idle", 32'(busy), 0);
    @(negedge clk_3125KHz);
    check("empty_pulse_end", 32'(path_empty), 0);

    // Overflow: 18 stores, only the first 16 delivered
    req = 2'b01;
    wait_gnt(g);
    req = 2'b00;
    launch_wait(hi);
    for (int i = 1; i <= 18; i++) store(A_NODE, 32'(i));
    store(A_DONE, 32'd1);
    check("ovf_flag", 32'(overflow), 1);
    drain_collect(4'b1111);
    check("ovf_beats", 32'(got_q.size()), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < got_q.size()) check("ovf_node", 32'(got_q[i]), 32'(i + 1));
    end
    check("ovf_sticky", 32'(overflow), 1);

    // Timeout: no DONE store
    req = 2'b10;
    wait_gnt(g);
    req = 2'b00;
    check("tmo_gnt", 32'(g), 32'd2);
    check("ovf_cleared", 32'(overflow), 0);
    for (k = 1; k <= 100; k++) begin
      @(negedge clk_3125KHz);
      if (timeout_err) break;
    end
    check("tmo_latency", 32'(k), TIMEOUT);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_start_low", 32'(cpu_start), 0);
    @(negedge clk_3125KHz);
    check("tmo_pulse_end", 32'(timeout_err), 0);
    check("tmo_no_regrant", 32'(gnt), 0);

    // Async reset in the middle of DRAIN
    sp0 = 5'd2; req = 2'b01;
    wait_gnt(g);
    req = 2'b00;
    launch_wait(hi);
    store(A_NODE, 32'd7);
    store(A_NODE, 32'd9);
    store(A_NODE, 32'd11);
    store(A_DONE, 32'd1);
    check("ar_valid_before", 32'(node_valid), 1);
    #40 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(node_valid), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_start", 32'(cpu_start), 0);
    @(negedge clk_3125KHz);
    rst_n = 1'b1;
    req = 2'b01;
    wait_gnt(g);
    req = 2'b00;
    check("ar_regrant", 32'(g), 32'd1);
    launch_wait(hi);
    check("ar_start_hold", 32'(hi), HOLD);
    store(A_NODE, 32'd4);
    store(A_DONE, 32'd1);
    drain_collect(4'b1111);
    check("ar_beats", 32'(got_q.size()), 1);
    if (got_q.size() == 1) check("ar_node", 32'(got_q[0]), 4);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
